// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX and RX: default frame/baud settings,
// the state encoding and a counter-width helper.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 5208;
    localparam int DEFAULT_DATA         = 8;
    localparam int UART_STATE_W         = 3;

    typedef enum logic [UART_STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_STOP      = 3'd3,
        ST_WAIT_HIGH = 3'd4
    } uart_state_t;

    // Bits needed to count 0..value-1; never narrower than one bit.
    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >> 1;
        end
        if (result < 1) begin
            result = 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for an asynchronous serial line; both flops reset
// to RESET_LEVEL so an idle line does not look like a start edge.
module uart_rx_sync
    import uart_pkg::*;
#(
    parameter logic RESET_LEVEL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= RESET_LEVEL;
            q    <= RESET_LEVEL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: start-bit validation at mid-bit, LSB-first data capture,
// stop-bit check with framing-error flag and break (line-low) lockout.
module uart_rx
    import uart_pkg::*;
#(
    parameter int DATA         = DEFAULT_DATA,
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            rx_in,
    output logic [DATA-1:0] rx_data,
    output logic            rx_valid,
    output logic            rx_busy,
    output logic            rx_frame_err
);

    localparam int CW = clog2(CLKS_PER_BIT);
    localparam int BW = clog2(DATA);
    localparam int H  = (CLKS_PER_BIT - 1) / 2;

    localparam logic [CW-1:0] CNT_HALF = CW'(H);
    localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA - 1);

    logic            rxs;
    uart_state_t     state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [BW-1:0]   bit_idx, bit_next;
    logic [DATA-1:0] shift, shift_next;
    logic [DATA-1:0] data_next;
    logic            valid_next;
    logic            err_next;

    uart_rx_sync #(.RESET_LEVEL(1'b1)) u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx_in),
        .q     (rxs)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            cnt          <= '0;
            bit_idx      <= '0;
            shift        <= '0;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            bit_idx      <= bit_next;
            shift        <= shift_next;
            rx_data      <= data_next;
            rx_valid     <= valid_next;
            rx_frame_err <= err_next;
        end
    end

    // Leaving STOP at mid-bit gives half a bit of slack to catch the next start edge.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        bit_next   = bit_idx;
        shift_next = shift;
        data_next  = rx_data;
        valid_next = 1'b0;
        err_next   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (!rxs) begin
                    state_next = ST_START;
                    cnt_next   = '0;
                end
            end
            ST_START: begin
                if (cnt == CNT_HALF) begin
                    cnt_next = '0;
                    if (!rxs) begin
                        state_next = ST_DATA;
                        bit_next   = '0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            ST_DATA: begin
                if (cnt == CNT_LAST) begin
                    cnt_next   = '0;
                    shift_next = {rxs, shift[DATA-1:1]};
                    bit_next   = bit_idx + BW'(1);
                    if (bit_idx == BIT_LAST) begin
                        state_next = ST_STOP;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            ST_STOP: begin
                if (cnt == CNT_LAST) begin
                    cnt_next = '0;
                    if (rxs) begin
                        data_next  = shift;
                        valid_next = 1'b1;
                        state_next = ST_IDLE;
                    end else begin
                        err_next   = 1'b1;
                        state_next = ST_WAIT_HIGH;
                    end
                end else begin
                    cnt_next = cnt + CW'(1);
                end
            end
            ST_WAIT_HIGH: begin
                if (rxs) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    assign rx_busy = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: a serial-line driver stands in for the TX and a
// scoreboard queue holds the bytes expected on each rx_valid pulse.
module tb_uart_rx;

    localparam int CPB = 16;
    localparam int DW  = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          rx_in = 1'b1;
    logic [DW-1:0] rx_data;
    logic          rx_valid;
    logic          rx_busy;
    logic          rx_frame_err;

    int            total_checks = 0;
    int            passed_checks = 0;
    int            cycle = 0;
    int            valid_pulses = 0;
    int            err_pulses = 0;
    int            valid_cycles[$];
    logic [DW-1:0] sb[$];
    logic [DW-1:0] mon_exp;
    logic [DW-1:0] loop_bytes[4] = '{8'hD3, 8'hA5, 8'h3C, 8'h55};
    logic [DW-1:0] abort_byte = 8'hF0;

    uart_rx #(.DATA(DW), .CLKS_PER_BIT(CPB)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_in        (rx_in),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_busy      (rx_busy),
        .rx_frame_err (rx_frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total_checks++;
        assert (observed === expected) passed_checks++;
        else $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic driveBit(input logic v);
        rx_in = v;
        repeat (CPB) @(negedge clk);
    endtask

    // One full frame on the line; the byte is queued only if a valid pulse is due.
    task automatic applyStimulus(input logic [DW-1:0] data, input logic stop_val, input logic expect_ok);
        if (expect_ok) sb.push_back(data);
        driveBit(1'b0);
        for (int i = 0; i < DW; i++) driveBit(data[i]);
        driveBit(stop_val);
    endtask

    // Output monitor: every pulse is checked against the scoreboard.
    always @(negedge clk) begin
        if (rx_valid || rx_frame_err)
            checkOutput("valid_err_exclusive", 32'(rx_valid & rx_frame_err), 32'd0);
        if (rx_frame_err) err_pulses++;
        if (rx_valid) begin
            valid_pulses++;
            valid_cycles.push_back(cycle);
            checkOutput("valid_expected", 32'(rx_valid), 32'(sb.size() != 0));
            if (sb.size() != 0) begin
                mon_exp = sb.pop_front();
                checkOutput("rx_data", 32'(rx_data), 32'(mon_exp));
            end
        end
    end

    initial begin
        int v0;
        int e0;
        int n0;
        int busy_cycles;

        // Reset values
        reset = 1'b1;
        rx_in = 1'b1;
        idle(3);
        checkOutput("reset_rx_data", 32'(rx_data), 32'd0);
        checkOutput("reset_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("reset_rx_busy", 32'(rx_busy), 32'd0);
        checkOutput("reset_rx_frame_err", 32'(rx_frame_err), 32'd0);
        reset = 1'b0;
        idle(5);

        // Back-to-back frames
        $display("[TB] back-to-back frames");
        v0 = valid_pulses;
        e0 = err_pulses;
        for (int i = 0; i < 4; i++) applyStimulus(loop_bytes[i], 1'b1, 1'b1);
        idle(20);
        checkOutput("loop_valid_count", 32'(valid_pulses - v0), 32'd4);
        checkOutput("loop_err_count", 32'(err_pulses - e0), 32'd0);
        checkOutput("loop_sb_empty", 32'(sb.size()), 32'd0);

        // Glitch: 3 low cycles must be rejected at the mid-start check
        $display("[TB] glitch start bit");
        v0 = valid_pulses;
        e0 = err_pulses;
        busy_cycles = 0;
        rx_in = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rx_busy) busy_cycles++;
            if (i == 2) rx_in = 1'b1;
        end
        checkOutput("glitch_busy_window", 32'(busy_cycles >= 1 && busy_cycles <= 9), 32'd1);
        checkOutput("glitch_busy_low", 32'(rx_busy), 32'd0);
        checkOutput("glitch_valid_count", 32'(valid_pulses - v0), 32'd0);
        checkOutput("glitch_err_count", 32'(err_pulses - e0), 32'd0);
        checkOutput("glitch_rx_data", 32'(rx_data), 32'h55);

        // Framing error followed by a break, then a good frame
        $display("[TB] framing error");
        v0 = valid_pulses;
        e0 = err_pulses;
        applyStimulus(8'h81, 1'b0, 1'b0);
        idle(40);
        checkOutput("ferr_busy_during_break", 32'(rx_busy), 32'd1);
        checkOutput("ferr_err_count", 32'(err_pulses - e0), 32'd1);
        checkOutput("ferr_valid_count", 32'(valid_pulses - v0), 32'd0);
        checkOutput("ferr_rx_data_kept", 32'(rx_data), 32'h55);
        rx_in = 1'b1;
        idle(5);
        checkOutput("ferr_busy_released", 32'(rx_busy), 32'd0);
        applyStimulus(8'h7E, 1'b1, 1'b1);
        idle(20);
        checkOutput("ferr_next_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("ferr_next_rx_data", 32'(rx_data), 32'h7E);

        // Reset during bit 4 of a 0xF0 frame
        $display("[TB] reset mid-frame");
        v0 = valid_pulses;
        e0 = err_pulses;
        driveBit(1'b0);
        for (int i = 0; i < 4; i++) driveBit(abort_byte[i]);
        rx_in = abort_byte[4];
        idle(8);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_rx_data", 32'(rx_data), 32'd0);
        checkOutput("midrst_rx_valid", 32'(rx_valid), 32'd0);
        checkOutput("midrst_rx_busy", 32'(rx_busy), 32'd0);
        checkOutput("midrst_rx_frame_err", 32'(rx_frame_err), 32'd0);
        reset = 1'b0;
        rx_in = 1'b1;
        idle(100);
        checkOutput("midrst_valid_count", 32'(valid_pulses - v0), 32'd0);
        checkOutput("midrst_err_count", 32'(err_pulses - e0), 32'd0);
        applyStimulus(8'h0F, 1'b1, 1'b1);
        idle(20);
        checkOutput("midrst_next_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("midrst_next_rx_data", 32'(rx_data), 32'h0F);

        // 0x00 then 0xFF with a single stop bit between them
        $display("[TB] extreme patterns");
        n0 = valid_cycles.size();
        applyStimulus(8'h00, 1'b1, 1'b1);
        applyStimulus(8'hFF, 1'b1, 1'b1);
        idle(20);
        checkOutput("ext_valid_count", 32'(valid_cycles.size() - n0), 32'd2);
        if (valid_cycles.size() - n0 == 2)
            checkOutput("ext_spacing", 32'(valid_cycles[n0+1] - valid_cycles[n0]), 32'(10 * CPB));
        checkOutput("ext_sb_empty", 32'(sb.size()), 32'd0);
        checkOutput("ext_rx_data", 32'(rx_data), 32'hFF);

        $display("%0d/%0d checks passed", passed_checks, total_checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receiver, the downstream partner of `uart_protocol` (the TX).
- Consumes the serial line that `uart_protocol` drives on `tx_out`.
- Frame format: one start bit (0), DATA data bits LSB first, one stop bit (1), no parity. Same format as TX.
- Recovers each byte and presents it with a one-cycle `rx_valid` strobe.
- Flags framing errors; rejects glitch start bits.

Parameters:
- DATA, 8, data bits per frame. Must match TX.
- CLKS_PER_BIT, 5208, clk cycles per bit (50 MHz / 9600 baud). Minimum 4. Must match TX.

Ports:
- clk  input  1  system clock, single domain.
- reset  input  1  synchronous, active-high reset.
- rx_in  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA  last correctly received byte.
- rx_valid  output  1  one-cycle pulse; rx_data updated this cycle.
- rx_busy  output  1  high while a frame is in progress (any state except IDLE).
- rx_frame_err  output  1  one-cycle pulse; stop bit was sampled low.

Behaviour:
- Clock and reset: one clock `clk`. `reset` is synchronous, active-high, and wins over all other activity.
- Reset values:
  - rx_data = 0, rx_valid = 0, rx_busy = 0, rx_frame_err = 0.
  - Synchronizer flops = 1. State = IDLE. Bit counter and baud counter = 0. Shift register = 0.
- Synchronizer: 2-flop on rx_in. All logic uses the synchronized signal `rxs`, so there is a 2-cycle input latency.
- Definitions: H = (CLKS_PER_BIT-1)/2 (integer division). Baud counter width = clog2(CLKS_PER_BIT).
- States: IDLE, START, DATA_BITS, STOP, WAIT_HIGH.
  - IDLE: if rxs==0, go to START with cnt=0 (call this cycle t0).
  - START: cnt increments each cycle. At cnt==H, sample rxs:
    - 0: go to DATA_BITS with cnt=0, bit=0.
    - 1: false start; go to IDLE. No pulses, rx_data unchanged.
  - DATA_BITS: at cnt==CLKS_PER_BIT-1, sample rxs, shift it in LSB first, cnt=0, bit++. After bit DATA-1 is sampled, go to STOP.
  - STOP: at cnt==CLKS_PER_BIT-1, sample rxs:
    - 1: rx_data <= shift register, rx_valid=1 for the next cycle only, go to IDLE.
    - 0: rx_frame_err=1 for the next cycle only, rx_data unchanged, go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs==1, then go to IDLE. This stops a break condition (line held low) from being decoded as 0x00 frames.
- Timing:
  - Start-bit check happens at t0+1+H.
  - Each data sample follows the previous sample by exactly CLKS_PER_BIT cycles, so every sample lands mid-bit.
  - Stop sample happens at t0+1+H+(DATA+1)*CLKS_PER_BIT.
  - rx_valid or rx_frame_err is high in the cycle after the stop sample.
- Back-to-back frames: returning to IDLE at mid-stop-bit lets a start edge directly after the stop bit be detected with no lost frame.
- rx_valid and rx_frame_err are never high in the same cycle.
- rx_busy rises in the cycle after t0. It falls in the same cycle rx_valid rises, or when WAIT_HIGH exits.
- Reset mid-frame: abort immediately and apply the reset values. The partial byte is discarded and no pulse is generated.
- rx_in held low through reset release: after the sync delay the receiver enters START. That is legal; a real start bit is expected.

Decomposition:
- Shared package `uart_pkg`, used by both TX and RX:
  - UART state encoding localparams.
  - Default CLKS_PER_BIT and DATA.
  - A clog2 function for counter widths.
- One sub-module, `uart_rx_sync`: the 2-flop synchronizer with reset value 1, parameterizable reset level.
- FSM, baud counter and shift register all live in uart_rx.

Test Plan:
- Bench setup: CLKS_PER_BIT=16 (H=7), DATA=8. Check timing relative to rxs exactly, or within ±2 cycles of a raw rx_in edge.
- Loopback: uart_protocol tx_out → rx_in, send 0xD3, 0xA5, 0x3C, 0x55 back-to-back. Expect exactly 4 rx_valid pulses with rx_data = D3, A5, 3C, 55 in order, and rx_frame_err never high.
- Glitch: drive rx_in low for 3 cycles, then high. Expect rx_busy high ≤ 9 cycles, then low, with no rx_valid, no rx_frame_err, rx_data unchanged.
- Framing error: send a frame for 0x81 with the stop bit driven 0 and the line held low for 40 more cycles. Expect:
  - one rx_frame_err pulse, no rx_valid, rx_data keeps the previous value;
  - rx_busy high until the line returns high;
  - a following valid 0x7E frame received correctly.
- Reset mid-frame: assert reset for 1 cycle during bit 4 of a 0xF0 frame. Expect all outputs 0 the next cycle, no pulse for the aborted frame, and the next full 0x0F frame received as 0x0F.
- Extremes: frames 0x00 and 0xFF sent with the minimum one-bit stop between them. Expect rx_valid pulses with 00 then FF, spaced exactly 10*16 = 160 cycles apart.
